mem_arbiter: RTL and testbench

Two-port request/grant arbiter that shares the single-port 64 KiB byte-addressed RAM between the CPU (port 0) and the DMA/program loader (port 1). It serializes accesses and drives the RAM's `we`, `addr` and `wdata` from registers. It also captures the RAM's registered read data and returns it to the requester that issued the read. It sits between both masters and the RAM instance. No other block drives the RAM.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes CPU (port 0) and DMA/loader (port 1) accesses onto a single-port
// byte-addressed RAM with registered read data. All outputs are registered.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req0/1, we0/1            per-port request and write flag (held until gnt)
//   addr0/1, wdata0/1        per-port byte address and write data
//   gnt0/1                   one-cycle pulse, request accepted
//   rvalid0/1, rdata0/1      one-cycle read-return pulse; rdata held until the port's next read
//   busy                     high while an access is in flight (not idle)
//   ram_we, ram_addr,        RAM command, driven only from registers
//   ram_wdata
//   ram_rdata                RAM registered read data
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e state_q;
    logic   owner_q;     // port that owns the access in flight
    logic   last_gnt_q;  // port granted most recently; resets to 1 so port 0 wins first
    logic   winner;

    // Winner for the current IDLE cycle; only used when at least one request is present.
    always_comb begin
        if (req0 && req1) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_gnt_q;
        end else begin
            winner = req1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            busy       <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            // Pulses default low every cycle.
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    ram_we <= 1'b0;
                    if (req0 || req1) begin
                        ram_we     <= winner ? we1 : we0;
                        ram_addr   <= winner ? addr1 : addr0;
                        ram_wdata  <= winner ? wdata1 : wdata0;
                        gnt0       <= ~winner;
                        gnt1       <= winner;
                        owner_q    <= winner;
                        last_gnt_q <= winner;
                        busy       <= 1'b1;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    // RAM performs the access at the end of this cycle.
                    if (ram_we) begin
                        ram_we  <= 1'b0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (owner_q) begin
                        rdata1  <= ram_rdata;
                        rvalid1 <= 1'b1;
                    end else begin
                        rdata0  <= ram_rdata;
                        rvalid0 <= 1'b1;
                    end
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    ram_we  <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural RAM, a transaction-level
// timing/arbitration model, per-port expected-read-data queues, and a second instance
// built with fixed priority.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy, ram_we;
    logic [7:0]  rdata0, rdata1, ram_wdata, ram_rdata;
    logic [15:0] ram_addr;

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Single-port RAM with registered read data.
    logic [7:0] ram [65536];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    // Fixed-priority instance, write-only traffic.
    logic        f_req0 = 1'b0, f_req1 = 1'b0;
    logic        f_gnt0, f_gnt1, f_rv0, f_rv1, f_busy, f_we;
    logic [7:0]  f_rd0, f_rd1, f_wd;
    logic [15:0] f_addr;

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .FIXED_PRIO(1)) dut_f (
        .clk(clk), .rst(rst),
        .req0(f_req0), .req1(f_req1), .we0(1'b1), .we1(1'b1),
        .addr0(16'h0100), .addr1(16'h8100), .wdata0(8'h5A), .wdata1(8'hA5),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .rvalid0(f_rv0), .rvalid1(f_rv1),
        .rdata0(f_rd0), .rdata1(f_rd1), .busy(f_busy),
        .ram_we(f_we), .ram_addr(f_addr), .ram_wdata(f_wd), .ram_rdata(8'h00)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event with no expectation at %0t", name, $time);
    endfunction

    // Reference memory contents and expected read data per port.
    logic [7:0] mem_m [65536];
    logic [7:0] exp_rd0 [$];
    logic [7:0] exp_rd1 [$];

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } cmd_t;
    cmd_t cq0 [$];
    cmd_t cq1 [$];

    // ---------------- monitor / transaction-level model ----------------
    int          cyc = 0;
    int          m_busy_until = 0;  // last cycle the arbiter is occupied
    int          rv_due = -1;       // cycle in which a read return is expected
    logic        rv_port = 1'b0;
    logic        m_last = 1'b1;
    logic        p_req0 = 1'b0, p_req1 = 1'b0, p_we0 = 1'b0, p_we1 = 1'b0;
    logic [15:0] p_addr0 = '0, p_addr1 = '0, e_addr = '0;
    logic [7:0]  p_wd0 = '0, p_wd1 = '0, e_wd = '0, e_rd0 = '0, e_rd1 = '0;
    logic        eg0, eg1, ewe, erv0, erv1, win;
    int          gcnt0 = 0, gcnt1 = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("reset_ctl", 32'({gnt0, gnt1, rvalid0, rvalid1, busy, ram_we}), 0);
            chk("reset_addr", 32'(ram_addr), 0);
            chk("reset_data", 32'({ram_wdata, rdata0, rdata1}), 0);
            m_busy_until = cyc;
            rv_due = -1;
            m_last = 1'b1;
            e_addr = '0; e_wd = '0; e_rd0 = '0; e_rd1 = '0;
            exp_rd0.delete();
            exp_rd1.delete();
        end else begin
            eg0 = 1'b0; eg1 = 1'b0; ewe = 1'b0; erv0 = 1'b0; erv1 = 1'b0;
            // Requests seen during an idle cycle are granted in the following cycle.
            if ((cyc - 1 > m_busy_until) && (p_req0 || p_req1)) begin
                win    = (p_req0 && p_req1) ? ~m_last : p_req1;
                m_last = win;
                if (win) begin
                    eg1 = 1'b1; ewe = p_we1; e_addr = p_addr1; e_wd = p_wd1;
                end else begin
                    eg0 = 1'b1; ewe = p_we0; e_addr = p_addr0; e_wd = p_wd0;
                end
                m_busy_until = ewe ? cyc : cyc + 1;
                if (!ewe) begin
                    rv_due  = cyc + 2;
                    rv_port = win;
                end
            end
            if (cyc == rv_due) begin
                if (rv_port) erv1 = 1'b1;
                else         erv0 = 1'b1;
            end
            chk("gnt0", 32'(gnt0), 32'(eg0));
            chk("gnt1", 32'(gnt1), 32'(eg1));
            chk("ram_we", 32'(ram_we), 32'(ewe));
            chk("busy", 32'(busy), 32'(cyc <= m_busy_until));
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
            chk("rvalid0", 32'(rvalid0), 32'(erv0));
            chk("rvalid1", 32'(rvalid1), 32'(erv1));
            if (rvalid0) begin
                if (exp_rd0.size() == 0) note_fail("rd0_queue");
                else e_rd0 = exp_rd0.pop_front();
            end
            if (rvalid1) begin
                if (exp_rd1.size() == 0) note_fail("rd1_queue");
                else e_rd1 = exp_rd1.pop_front();
            end
            chk("rdata0", 32'(rdata0), 32'(e_rd0));
            chk("rdata1", 32'(rdata1), 32'(e_rd1));
            if (gnt0) gcnt0++;
            if (gnt1) gcnt1++;
        end
        p_req0 = req0; p_we0 = we0; p_addr0 = addr0; p_wd0 = wdata0;
        p_req1 = req1; p_we1 = we1; p_addr1 = addr1; p_wd1 = wdata1;
    end

    // ---------------- stimulus ----------------
    task automatic push(input bit p, input logic w, input logic [15:0] a, input logic [7:0] d);
        cmd_t c;
        c.we = w; c.addr = a; c.wdata = d;
        if (p) cq1.push_back(c);
        else   cq0.push_back(c);
    endtask

    // Presenting a command is the point where its expected effect enters the model.
    task automatic present(input bit p, input cmd_t c);
        if (c.we) mem_m[c.addr] = c.wdata;
        else if (p) exp_rd1.push_back(mem_m[c.addr]);
        else exp_rd0.push_back(mem_m[c.addr]);
        if (p) begin
            req1 = 1'b1; we1 = c.we; addr1 = c.addr; wdata1 = c.wdata;
        end else begin
            req0 = 1'b1; we0 = c.we; addr0 = c.addr; wdata0 = c.wdata;
        end
    endtask

    // Feed both command queues; next command goes out on the grant cycle unless a gap is drawn.
    task automatic run_cmds(input int max_gap);
        int budget = 5000;
        int gap0 = 0;
        int gap1 = 0;
        while (budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
            if (req0 && gnt0) req0 = 1'b0;
            if (req1 && gnt1) req1 = 1'b0;
            if (!req0) begin
                if (gap0 > 0) gap0--;
                else if (cq0.size() > 0) begin
                    present(1'b0, cq0.pop_front());
                    gap0 = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
                end
            end
            if (!req1) begin
                if (gap1 > 0) gap1--;
                else if (cq1.size() > 0) begin
                    present(1'b1, cq1.pop_front());
                    gap1 = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
                end
            end
            if (cq0.size() == 0 && cq1.size() == 0 && !req0 && !req1 &&
                exp_rd0.size() == 0 && exp_rd1.size() == 0 && !busy) break;
        end
        if (budget == 0) begin
            note_fail("drain_timeout");
            cq0.delete(); cq1.delete();
            req0 = 1'b0; req1 = 1'b0;
        end
    endtask

    task automatic fixed_prio_test();
        int n0 = 0;
        int n1 = 0;
        @(posedge clk);
        #1;
        f_req0 = 1'b1;
        f_req1 = 1'b1;
        for (int k = 0; k < 200 && (f_req0 || f_req1); k++) begin
            @(posedge clk);
            #1;
            chk("fp_gnt_excl", 32'(f_gnt0 & f_gnt1), 0);
            if (f_gnt0) begin
                chk("fp_addr0", 32'(f_addr), 32'h0100);
                n0++;
                if (n0 == 8) f_req0 = 1'b0;
            end
            if (f_gnt1) begin
                chk("fp_gnt1_after_req0_drop", n0, 8);
                chk("fp_addr1", 32'(f_addr), 32'h8100);
                n1++;
                if (n1 == 8) f_req1 = 1'b0;
            end
        end
        chk("fp_n0", n0, 8);
        chk("fp_n1", n1, 8);
    endtask

    initial begin
        int g0, g1;
        bit seen;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        // Single write then read, port 0.
        push(1'b0, 1'b1, 16'h1234, 8'hA5); run_cmds(0);
        push(1'b0, 1'b0, 16'h1234, 8'h00); run_cmds(0);

        // Preload, then simultaneous reads.
        push(1'b0, 1'b1, 16'h0010, 8'h11); run_cmds(0);
        push(1'b1, 1'b1, 16'h0020, 8'h22); run_cmds(0);
        push(1'b0, 1'b0, 16'h0010, 8'h00);
        push(1'b1, 1'b0, 16'h0020, 8'h00);
        run_cmds(0);
        chk("sim_rdata0", 32'(rdata0), 32'h11);
        chk("sim_rdata1", 32'(rdata1), 32'h22);

        // Continuous contention, 8 writes per port.
        g0 = gcnt0; g1 = gcnt1;
        for (int i = 0; i < 8; i++) begin
            push(1'b0, 1'b1, 16'h0040 + 16'(i), 8'(i));
            push(1'b1, 1'b1, 16'h8040 + 16'(i), 8'h80 + 8'(i));
        end
        run_cmds(0);
        chk("cont_gnt0_count", gcnt0 - g0, 8);
        chk("cont_gnt1_count", gcnt1 - g1, 8);

        // Boundary addresses.
        push(1'b0, 1'b1, 16'hFFFF, 8'hFF);
        push(1'b0, 1'b1, 16'h0000, 8'h01);
        push(1'b0, 1'b0, 16'hFFFF, 8'h00);
        push(1'b0, 1'b0, 16'h0000, 8'h00);
        run_cmds(0);
        chk("bound_rdata0", 32'(rdata0), 32'h01);

        // Back-to-back port 1 writes and read-back.
        for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 16'h8000 + 16'(i), 8'hC0 + 8'(i));
        run_cmds(0);
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 16'h8000 + 16'(i), 8'h00);
        run_cmds(0);
        chk("b2b_last_rdata1", 32'(rdata1), 32'hC3);

        // Reset during write ISSUE: old value must survive.
        push(1'b0, 1'b1, 16'h0300, 8'h33); run_cmds(0);
        @(posedge clk);
        #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0300; wdata0 = 8'h77;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            seen = gnt0;
        end
        chk("rst_wr_gnt_seen", 32'(seen), 1);
        chk("rst_wr_issue_we", 32'(ram_we), 1);
        #2 rst = 1'b1;
        req0 = 1'b0;
        #1;
        chk("rst_async_ctl", 32'({gnt0, gnt1, rvalid0, rvalid1, busy, ram_we}), 0);
        chk("rst_async_addr", 32'(ram_addr), 0);
        chk("rst_async_data", 32'({ram_wdata, rdata0, rdata1}), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        push(1'b0, 1'b0, 16'h0300, 8'h00); run_cmds(0);
        chk("rst_wr_old_value", 32'(rdata0), 32'h33);

        // Randomized traffic on disjoint per-port regions.
        for (int i = 0; i < 16; i++) begin
            push(1'b0, 1'b1, 16'(i), 8'($urandom));
            push(1'b1, 1'b1, 16'h9000 + 16'(i), 8'($urandom));
        end
        run_cmds(2);
        for (int n = 0; n < 120; n++) begin
            push(1'b0, 1'($urandom), 16'($urandom_range(0, 15)), 8'($urandom));
            push(1'b1, 1'($urandom), 16'h9000 + 16'($urandom_range(0, 15)), 8'($urandom));
        end
        run_cmds(3);

        fixed_prio_test();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
